multicycle_controller: RTL and testbench

Parametrised multicycle control unit for the MIPS core, successor to the single-cycle `controller`. A registered FSM sequences each instruction over 3–5+ states and drives the shared-ALU/shared-memory datapath. Memory accesses use a variable-latency request/ready handshake, guarded by a wait watchdog. It sits beside the datapath in the processor top, taking the opcode from the instruction register.

---
 rtl/multicycle_controller_pkg.sv | 47 ++++
 rtl/multicycle_controller_wait_timer.sv | 34 +++
 rtl/multicycle_controller.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: opcode constants,
// datapath mux encodings and the 4-bit FSM state encoding.
package multicycle_controller_pkg;

  localparam int OPCODE_WIDTH = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // States that hold a memory access open until ready (watchdog applies)
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// Wait-cycle counter with timeout compare for memory accesses.
// expired is high on the MAX_WAIT-th consecutive counted cycle, so the
// caller can abort in that same cycle unless ready arrives.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic count,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt;

  // Count waiting cycles; clear has priority and the counter freezes with ce low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ce) begin
      if (clear) begin
        cnt <= '0;
      end else if (count) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign expired = (cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM driving a shared-ALU / shared-memory datapath.
// Optional feature macro: MULTICYCLE_JUMP_EN builds the JUMP state and
// decodes j; without it j is reported as illegal.
module multicycle_controller #(
  parameter int OPCODE_WIDTH = multicycle_controller_pkg::OPCODE_WIDTH,
  parameter int MAX_WAIT     = 15
) (
  input  logic                    mc_clk,
  input  logic                    mc_rst,
  input  logic                    mc_i_ce,
  input  logic [OPCODE_WIDTH-1:0] mc_i_opcode,
  input  logic                    mc_i_mem_ready,
  output logic                    mc_o_mem_req,
  output logic                    mc_o_IorD,
  output logic                    mc_o_MemWrite,
  output logic                    mc_o_IRWrite,
  output logic                    mc_o_PCWrite,
  output logic                    mc_o_Branch,
  output logic                    mc_o_RegDst,
  output logic                    mc_o_MemtoReg,
  output logic                    mc_o_RegWrite,
  output logic                    mc_o_ALUSrcA,
  output logic [1:0]              mc_o_ALUSrcB,
  output logic [1:0]              mc_o_ALUOp,
  output logic [1:0]              mc_o_PCSrc,
  output logic                    mc_o_retire,
  output logic                    mc_o_illegal,
  output logic                    mc_o_mem_err
);

  import multicycle_controller_pkg::*;

  state_t state;
  state_t state_next;
  state_t decode_target;
  logic   decode_legal;
  logic   in_wait;
  logic   expired;
  logic   timeout;

  assign in_wait = is_wait_state(state);
  // Ready in the same cycle as expiry wins: it is a normal completion
  assign timeout = in_wait & ~mc_i_mem_ready & expired;

  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (mc_clk),
    .rst     (mc_rst),
    .ce      (mc_i_ce),
    .count   (in_wait & ~mc_i_mem_ready),
    .clear   (mc_i_mem_ready | timeout | (state_next != state)),
    .expired (expired)
  );

  // State register; clock enable low freezes the FSM
  always_ff @(posedge mc_clk or posedge mc_rst) begin
    if (mc_rst) begin
      state <= S_FETCH;
    end else if (mc_i_ce) begin
      state <= state_next;
    end
  end

  // Opcode decode: dispatch target out of DECODE and legality flag
  always_comb begin
    decode_target = S_FETCH;
    decode_legal  = 1'b1;
    case (mc_i_opcode)
      OPCODE_WIDTH'(OP_RTYPE):              decode_target = S_EXEC;
      OPCODE_WIDTH'(OP_LW), OPCODE_WIDTH'(OP_SW): decode_target = S_MEMADR;
      OPCODE_WIDTH'(OP_BEQ):                decode_target = S_BRANCH;
      OPCODE_WIDTH'(OP_ADDI):               decode_target = S_ADDIEX;
`ifdef MULTICYCLE_JUMP_EN
      OPCODE_WIDTH'(OP_J):                  decode_target = S_JUMP;
`endif
      default:                              decode_legal  = 1'b0;
    endcase
  end

  // Next-state logic; wait states leave on ready or abort to FETCH on timeout
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mc_i_mem_ready)  state_next = S_DECODE;
        else if (timeout)    state_next = S_FETCH;
      end
      S_DECODE: state_next = decode_target;
      S_MEMADR: state_next = (mc_i_opcode == OPCODE_WIDTH'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mc_i_mem_ready)  state_next = S_MEMWB;
        else if (timeout)    state_next = S_FETCH;
      end
      S_MEMWR: begin
        if (mc_i_mem_ready || timeout) state_next = S_FETCH;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB: state_next = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:   state_next = S_FETCH;
`endif
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath controls per state, then ce gating of strobes and reset blanking
  always_comb begin
    mc_o_mem_req  = 1'b0;
    mc_o_IorD     = 1'b0;
    mc_o_MemWrite = 1'b0;
    mc_o_IRWrite  = 1'b0;
    mc_o_PCWrite  = 1'b0;
    mc_o_Branch   = 1'b0;
    mc_o_RegDst   = 1'b0;
    mc_o_MemtoReg = 1'b0;
    mc_o_RegWrite = 1'b0;
    mc_o_ALUSrcA  = 1'b0;
    mc_o_ALUSrcB  = SRCB_REG;
    mc_o_ALUOp    = ALUOP_ADD;
    mc_o_PCSrc    = PCSRC_ALU;
    mc_o_retire   = 1'b0;
    mc_o_illegal  = 1'b0;
    mc_o_mem_err  = timeout;
    case (state)
      S_FETCH: begin
        mc_o_mem_req = 1'b1;
        mc_o_ALUSrcB = SRCB_FOUR;
        mc_o_IRWrite = mc_i_mem_ready;
        mc_o_PCWrite = mc_i_mem_ready;
      end
      S_DECODE: begin
        mc_o_ALUSrcB = SRCB_IMM_SH;
        mc_o_illegal = ~decode_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        mc_o_ALUSrcA = 1'b1;
        mc_o_ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        mc_o_mem_req = 1'b1;
        mc_o_IorD    = 1'b1;
      end
      S_MEMWB: begin
        mc_o_RegWrite = 1'b1;
        mc_o_MemtoReg = 1'b1;
        mc_o_retire   = 1'b1;
      end
      S_MEMWR: begin
        mc_o_mem_req  = 1'b1;
        mc_o_IorD     = 1'b1;
        mc_o_MemWrite = ~timeout;
        mc_o_retire   = mc_i_mem_ready;
      end
      S_EXEC: begin
        mc_o_ALUSrcA = 1'b1;
        mc_o_ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        mc_o_RegWrite = 1'b1;
        mc_o_RegDst   = 1'b1;
        mc_o_retire   = 1'b1;
      end
      S_BRANCH: begin
        mc_o_ALUSrcA = 1'b1;
        mc_o_ALUOp   = ALUOP_SUB;
        mc_o_PCSrc   = PCSRC_ALUOUT;
        mc_o_Branch  = 1'b1;
        mc_o_retire  = 1'b1;
      end
      S_ADDIWB: begin
        mc_o_RegWrite = 1'b1;
        mc_o_retire   = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        mc_o_PCSrc   = PCSRC_JUMP;
        mc_o_PCWrite = 1'b1;
        mc_o_retire  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!mc_i_ce) begin
      mc_o_mem_req  = 1'b0;
      mc_o_MemWrite = 1'b0;
      mc_o_IRWrite  = 1'b0;
      mc_o_PCWrite  = 1'b0;
      mc_o_Branch   = 1'b0;
      mc_o_RegWrite = 1'b0;
      mc_o_retire   = 1'b0;
      mc_o_illegal  = 1'b0;
      mc_o_mem_err  = 1'b0;
    end
    if (mc_rst) begin
      mc_o_mem_req  = 1'b0;
      mc_o_IorD     = 1'b0;
      mc_o_MemWrite = 1'b0;
      mc_o_IRWrite  = 1'b0;
      mc_o_PCWrite  = 1'b0;
      mc_o_Branch   = 1'b0;
      mc_o_RegDst   = 1'b0;
      mc_o_MemtoReg = 1'b0;
      mc_o_RegWrite = 1'b0;
      mc_o_ALUSrcA  = 1'b0;
      mc_o_ALUSrcB  = 2'b00;
      mc_o_ALUOp    = 2'b00;
      mc_o_PCSrc    = 2'b00;
      mc_o_retire   = 1'b0;
      mc_o_illegal  = 1'b0;
      mc_o_mem_err  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios with
// literal expectations followed by randomized traffic checked every cycle
// against a micro-program style reference model.
module tb_multicycle_controller;

  localparam int MAXW = 15;
  localparam logic [5:0] K_R = 6'd0, K_LW = 6'd35, K_SW = 6'd43,
                         K_BEQ = 6'd4, K_ADDI = 6'd8, K_J = 6'd2, K_BAD = 6'd63;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce = 1'b1;
  logic       ready = 1'b1;
  logic [5:0] opcode = 6'd0;

  logic mem_req, iord, memwrite, irwrite, pcwrite, branch, regdst, memtoreg;
  logic regwrite, alusrca, retire, illegal, mem_err;
  logic [1:0] alusrcb, aluop, pcsrc;

  multicycle_controller #(.OPCODE_WIDTH(6), .MAX_WAIT(MAXW)) dut (
    .mc_clk(clk), .mc_rst(rst), .mc_i_ce(ce), .mc_i_opcode(opcode),
    .mc_i_mem_ready(ready), .mc_o_mem_req(mem_req), .mc_o_IorD(iord),
    .mc_o_MemWrite(memwrite), .mc_o_IRWrite(irwrite), .mc_o_PCWrite(pcwrite),
    .mc_o_Branch(branch), .mc_o_RegDst(regdst), .mc_o_MemtoReg(memtoreg),
    .mc_o_RegWrite(regwrite), .mc_o_ALUSrcA(alusrca), .mc_o_ALUSrcB(alusrcb),
    .mc_o_ALUOp(aluop), .mc_o_PCSrc(pcsrc), .mc_o_retire(retire),
    .mc_o_illegal(illegal), .mc_o_mem_err(mem_err)
  );

  always #5 clk = ~clk;

  wire [18:0] dut_w = {mem_req, iord, memwrite, irwrite, pcwrite, branch, regdst,
                       memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc,
                       retire, illegal, mem_err};

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an instruction is FETCH, DECODE, then a micro-program
  // chosen by opcode; wait steps hold until ready or the watchdog limit.
  localparam int T_FETCH = 0, T_DEC = 1, T_MADR = 2, T_MRD = 3, T_MWB = 4, T_MWR = 5,
                 T_EXEC = 6, T_AWB = 7, T_BR = 8, T_AIEX = 9, T_AIWB = 10, T_JMP = 11;

  int m_step = T_FETCH;
  int m_wait = 0;
  int m_prog[$];

  function automatic bit legal_op(input logic [5:0] op);
    bit l;
    l = (op == K_R) || (op == K_LW) || (op == K_SW) || (op == K_BEQ) || (op == K_ADDI);
`ifdef MULTICYCLE_JUMP_EN
    l = l || (op == K_J);
`endif
    return l;
  endfunction

  always @(negedge clk) begin
    logic mreq, io, mw, irw, pcw, br, rd, m2r, rw, asa, ret, ill, err, tmo, wstep;
    logic [1:0] asb, aop, pcs;
    logic [18:0] e;
    {mreq, io, mw, irw, pcw, br, rd, m2r, rw, asa, ret, ill, err} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    wstep = (m_step == T_FETCH) || (m_step == T_MRD) || (m_step == T_MWR);
    tmo = wstep && !ready && (m_wait + 1 == MAXW);
    err = tmo;
    case (m_step)
      T_FETCH: begin mreq = 1; asb = 2'b01; irw = ready; pcw = ready; end
      T_DEC:   begin asb = 2'b11; ill = !legal_op(opcode); end
      T_MADR:  begin asa = 1; asb = 2'b10; end
      T_MRD:   begin mreq = 1; io = 1; end
      T_MWB:   begin rw = 1; m2r = 1; ret = 1; end
      T_MWR:   begin mreq = 1; io = 1; mw = !tmo; ret = ready; end
      T_EXEC:  begin asa = 1; aop = 2'b10; end
      T_AWB:   begin rw = 1; rd = 1; ret = 1; end
      T_BR:    begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; ret = 1; end
      T_AIEX:  begin asa = 1; asb = 2'b10; end
      T_AIWB:  begin rw = 1; ret = 1; end
      T_JMP:   begin pcs = 2'b10; pcw = 1; ret = 1; end
      default: ;
    endcase
    if (!ce) {mreq, mw, irw, pcw, br, rw, ret, ill, err} = '0;
    e = {mreq, io, mw, irw, pcw, br, rd, m2r, rw, asa, asb, aop, pcs, ret, ill, err};
    if (rst) e = '0;
    chk($sformatf("cycle_outputs step=%0d", m_step), 32'(dut_w), 32'(e));

    if (rst) begin
      m_step = T_FETCH; m_wait = 0; m_prog.delete();
    end else if (ce) begin
      if (wstep && !ready && tmo) begin
        m_step = T_FETCH; m_wait = 0; m_prog.delete();
      end else if (wstep && !ready) begin
        m_wait++;
      end else begin
        m_wait = 0;
        if (m_step == T_FETCH) begin
          m_step = T_DEC;
        end else begin
          if (m_step == T_DEC) begin
            case (opcode)
              K_R:    begin m_prog.push_back(T_EXEC); m_prog.push_back(T_AWB); end
              K_LW:   begin m_prog.push_back(T_MADR); m_prog.push_back(T_MRD); m_prog.push_back(T_MWB); end
              K_SW:   begin m_prog.push_back(T_MADR); m_prog.push_back(T_MWR); end
              K_BEQ:  m_prog.push_back(T_BR);
              K_ADDI: begin m_prog.push_back(T_AIEX); m_prog.push_back(T_AIWB); end
`ifdef MULTICYCLE_JUMP_EN
              K_J:    m_prog.push_back(T_JMP);
`endif
              default: ;
            endcase
          end
          if (m_prog.size() == 0) m_step = T_FETCH;
          else m_step = m_prog.pop_front();
        end
      end
    end
  end

  // One clock cycle of stimulus; outputs are settled when the task returns
  task automatic cyc(input logic [5:0] op, input logic r, input logic c, input logic rs);
    @(posedge clk);
    #1;
    opcode = op; ready = r; ce = c; rst = rs;
    #2;
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return K_R;
      1: return K_LW;
      2: return K_SW;
      3: return K_BEQ;
      4: return K_ADDI;
      5: return K_J;
      6: return K_BAD;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    int rcnt;
    logic [5:0] op;
    int p;

    // Reset holds every output low
    cyc(K_R, 1, 1, 1);
    cyc(K_R, 1, 1, 1);
    chk("reset_all_zero", 32'(dut_w), 32'd0);

    // R then addi, zero-wait memory
    cyc(K_R, 1, 1, 0);
    chk("first_fetch_req_iord", 32'({mem_req, iord}), 32'b10);
    rcnt = 0;
    for (int c = 2; c <= 8; c++) begin
      cyc((c < 5) ? K_R : K_ADDI, 1, 1, 0);
      if (retire) rcnt++;
      if (c == 4) chk("r_retire_regdst_c4", 32'({retire, regdst, regwrite}), 32'b111);
      if (c == 8) chk("addi_retire_regdst_c8", 32'({retire, regdst, regwrite}), 32'b101);
    end
    chk("r_addi_retire_count", 32'(rcnt), 32'd2);

    // lw with three wait cycles in MEMRD
    for (int c = 1; c <= 8; c++) begin
      cyc(K_LW, (c >= 4 && c <= 6) ? 1'b0 : 1'b1, 1, 0);
      if (c >= 4 && c <= 7) chk("lw_memrd_held", 32'({mem_req, iord, retire}), 32'b110);
      if (c == 8) chk("lw_memwb", 32'({regwrite, memtoreg, regdst, retire}), 32'b1101);
    end

    // sw never ready: abort on the 15th MEMWR cycle
    for (int c = 1; c <= 18; c++) begin
      cyc(K_SW, (c >= 4) ? 1'b0 : 1'b1, 1, 0);
      if (c == 17) chk("sw_wait_c17", 32'({mem_err, memwrite, retire}), 32'b010);
      if (c == 18) chk("sw_timeout_c18", 32'({mem_err, memwrite, retire}), 32'b100);
    end
    // Retry: ready on the 15th MEMWR cycle completes normally
    cyc(K_SW, 1, 1, 0);
    chk("sw_after_abort_fetch", 32'({mem_req, iord, alusrcb}), 32'b1001);
    for (int c = 2; c <= 18; c++) begin
      cyc(K_SW, (c >= 4 && c <= 17) ? 1'b0 : 1'b1, 1, 0);
      if (c == 18) chk("sw_ready_on_limit", 32'({retire, mem_err, memwrite}), 32'b101);
    end

    // Unsupported opcode, then j
    cyc(K_BAD, 1, 1, 0);
    cyc(K_BAD, 1, 1, 0);
    chk("illegal_in_decode", 32'({illegal, regwrite, pcwrite}), 32'b100);
    cyc(K_J, 1, 1, 0);
    chk("fetch_after_illegal", 32'({mem_req, iord, illegal}), 32'b100);
    cyc(K_J, 1, 1, 0);
`ifdef MULTICYCLE_JUMP_EN
    chk("j_decode_legal", 32'(illegal), 32'd0);
    cyc(K_J, 1, 1, 0);
    chk("j_jump_c3", 32'({pcwrite, pcsrc, retire}), 32'b1101);
`else
    chk("j_decode_illegal", 32'(illegal), 32'd1);
    cyc(K_J, 0, 1, 0);
    chk("j_back_to_fetch", 32'({mem_req, iord, irwrite, pcsrc}), 32'b10000);
`endif

    // Clock enable low for two cycles in EXEC
    cyc(K_R, 1, 1, 0);
    cyc(K_R, 1, 1, 0);
    for (int c = 3; c <= 4; c++) begin
      cyc(K_R, 1, 0, 0);
      chk("ce_low_exec", 32'({aluop, alusrca, regwrite, retire, mem_req}), 32'b101000);
    end
    cyc(K_R, 1, 1, 0);
    chk("ce_back_exec", 32'({aluop, regwrite}), 32'b100);
    cyc(K_R, 1, 1, 0);
    chk("ce_then_aluwb", 32'({regwrite, regdst, retire}), 32'b111);

    // Reset in the middle of MEMRD
    cyc(K_LW, 1, 1, 0);
    cyc(K_LW, 1, 1, 0);
    cyc(K_LW, 1, 1, 0);
    cyc(K_LW, 0, 1, 0);
    chk("lw_in_memrd", 32'({mem_req, iord}), 32'b11);
    cyc(K_LW, 0, 1, 1);
    chk("reset_mid_memrd", 32'(dut_w), 32'd0);
    cyc(K_LW, 1, 1, 0);
    chk("fetch_after_reset", 32'({mem_req, iord}), 32'b10);

    // Randomized traffic; opcode only changes while the model sits in FETCH
    op = opcode;
    for (int i = 0; i < 4000; i++) begin
      p = (i < 2000) ? 90 : 8;
      if (m_step == T_FETCH) op = pick_op();
      cyc(op, ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0,
          ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
